// File: rtl/mux_tree_pkg.sv
// Shared helpers for the pipelined radix-4 word multiplexer tree.
// Tree depth and per-level word counts are derived here so every file agrees.
package mux_tree_pkg;

    localparam int MAX_N_IN = 256;

    function automatic int clog2_f(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r++;
        end
        return r;
    endfunction

    // Radix-4 levels, with a trailing radix-2 level when the select width is odd.
    function automatic int levels_f(input int n);
        return (clog2_f(n) + 1) / 2;
    endfunction

    function automatic int words_at_f(input int n, input int k);
        int w;
        w = n;
        for (int i = 0; i <= k; i++) begin
            w = (w >= 4) ? (w / 4) : 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/mux_tree_pipe_mux4_w.sv
// Combinational WIDTH-bit 4:1 word multiplexer used as the tree's building block.
module mux4_w
    import mux_tree_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    input  logic [1:0]       sel,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        case (sel)
            2'd0:    y = d0;
            2'd1:    y = d1;
            2'd2:    y = d2;
            default: y = d3;
        endcase
    end

endmodule

// File: rtl/mux_tree_pipe.sv
// Pipelined N:1 word multiplexer: radix-4 tree, one register stage per level,
// valid/ready at both ends with a combinational back-pressure chain.
module mux_tree_pipe
    import mux_tree_pkg::*;
#(
    parameter  int N_IN   = 16,
    parameter  int WIDTH  = 64,
    localparam int SEL_W  = $clog2(N_IN),
    localparam int LEVELS = levels_f(N_IN)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [SEL_W-1:0]      in_sel,
    input  logic [N_IN*WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_data
);

    if (N_IN < 2 || N_IN > MAX_N_IN || (N_IN & (N_IN - 1)) != 0) begin : g_bad_n
        $error("mux_tree_pipe: N_IN must be a power of two in 2..256");
    end

    logic [LEVELS-1:0] valid_q;
    logic [LEVELS-1:0] valid_d;
    logic [LEVELS-1:0] load;

    // A stage may load when it is empty or when the stage after it is draining.
    always_comb begin
        load = '0;
        load[LEVELS-1] = ~valid_q[LEVELS-1] | out_ready;
        for (int k = LEVELS - 2; k >= 0; k--) begin
            load[k] = ~valid_q[k] | load[k+1];
        end
        in_ready = load[0] & ~flush;
    end

    always_comb begin
        valid_d = valid_q;
        if (flush) begin
            valid_d = '0;
        end else begin
            if (load[0]) begin
                valid_d[0] = in_valid;
            end
            for (int k = 1; k < LEVELS; k++) begin
                if (load[k]) begin
                    valid_d[k] = valid_q[k-1];
                end
            end
        end
    end

    // NOTE: state registers take <= so every stage samples its neighbour's pre-edge value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    assign out_valid = valid_q[LEVELS-1];

    for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
        localparam int W_IN  = (k == 0) ? N_IN : words_at_f(N_IN, k - 1);
        localparam int W_OUT = words_at_f(N_IN, k);
        localparam int S_IN  = SEL_W - 2 * k;
        localparam int S_OUT = (S_IN > 2) ? (S_IN - 2) : 0;

        logic [W_IN*WIDTH-1:0]  src_data;
        logic [S_IN-1:0]        src_sel;
        logic                   src_valid;
        logic                   take;
        logic [1:0]             mux_sel;
        logic [W_OUT*WIDTH-1:0] red_data;
        logic [W_OUT*WIDTH-1:0] data_d;
        logic [W_OUT*WIDTH-1:0] data_q;

        if (k == 0) begin : g_src
            assign src_data  = in_data;
            assign src_sel   = in_sel;
            assign src_valid = in_valid & in_ready;
        end else begin : g_src
            assign src_data  = g_lvl[k-1].data_q;
            assign src_sel   = g_lvl[k-1].g_sel.sel_q;
            assign src_valid = valid_q[k-1];
        end

        assign take = load[k] & src_valid;

        if (S_IN == 1) begin : g_r2
            assign mux_sel = {1'b0, src_sel[0]};
            mux4_w #(.WIDTH(WIDTH)) u_mux (
                .d0  (src_data[0 +: WIDTH]),
                .d1  (src_data[WIDTH +: WIDTH]),
                .d2  ('0),
                .d3  ('0),
                .sel (mux_sel),
                .y   (red_data)
            );
        end else begin : g_r4
            assign mux_sel = src_sel[1:0];
            for (genvar j = 0; j < W_OUT; j++) begin : g_word
                mux4_w #(.WIDTH(WIDTH)) u_mux (
                    .d0  (src_data[(4*j+0)*WIDTH +: WIDTH]),
                    .d1  (src_data[(4*j+1)*WIDTH +: WIDTH]),
                    .d2  (src_data[(4*j+2)*WIDTH +: WIDTH]),
                    .d3  (src_data[(4*j+3)*WIDTH +: WIDTH]),
                    .sel (mux_sel),
                    .y   (red_data[j*WIDTH +: WIDTH])
                );
            end
        end

        always_comb begin
            data_d = take ? red_data : data_q;
        end

        // NOTE: data registers are reset as well, so out_data reads 0 straight out of reset.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                data_q <= '0;
            end else begin
                data_q <= data_d;
            end
        end

        // Select bits not yet consumed travel with the data to the next level.
        if (S_OUT > 0) begin : g_sel
            logic [S_OUT-1:0] sel_d;
            logic [S_OUT-1:0] sel_q;

            always_comb begin
                sel_d = take ? src_sel[S_IN-1:2] : sel_q;
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sel_q <= '0;
                end else begin
                    sel_q <= sel_d;
                end
            end
        end

        if (k == LEVELS - 1) begin : g_out
            assign out_data = data_q;
        end
    end

endmodule

// File: tb/tb_mux_tree_pipe.sv
// Scoreboard bench for mux_tree_pipe: a 16x8 instance (even select width)
// and an 8x16 instance (odd select width, radix-2 last level).
module tb_mux_tree_pipe;

    localparam int N_A = 16;
    localparam int W_A = 8;
    localparam int N_B = 8;
    localparam int W_B = 16;
    localparam int LAT = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic               a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [3:0]         a_in_sel;
    logic [N_A*W_A-1:0] a_in_data;
    logic [W_A-1:0]     a_out_data;

    logic               b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [2:0]         b_in_sel;
    logic [N_B*W_B-1:0] b_in_data;
    logic [W_B-1:0]     b_out_data;

    mux_tree_pipe #(.N_IN(N_A), .WIDTH(W_A)) u_dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (a_flush),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .in_sel    (a_in_sel),
        .in_data   (a_in_data),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .out_data  (a_out_data)
    );

    mux_tree_pipe #(.N_IN(N_B), .WIDTH(W_B)) u_dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (b_flush),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_sel    (b_in_sel),
        .in_data   (b_in_data),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_data  (b_out_data)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] exp_a(input logic [3:0] s);
        logic [7:0] w;
        w = 8'h11 * s;
        return {8'h00, w};
    endfunction

    function automatic logic [15:0] exp_b(input logic [2:0] s);
        logic [15:0] w;
        w = 16'h0101 * s;
        return w;
    endfunction

    typedef struct {
        logic [15:0] data;
        int          cyc;
    } exp_t;

    exp_t       qa[$];
    exp_t       qb[$];
    exp_t       ea;
    exp_t       eb;
    int         cyc = 0;
    bit         lat_chk = 1'b0;
    bit         prev_stall_a = 1'b0;
    logic [7:0] prev_data_a;
    bit         prev_stall_b = 1'b0;
    logic [15:0] prev_data_b;

    // Scoreboard: pushes on accepted inputs, pops on output handshakes.
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            qa.delete();
            qb.delete();
            prev_stall_a = 1'b0;
            prev_stall_b = 1'b0;
        end else begin
            if (prev_stall_a) begin
                check("a_hold_valid", a_out_valid, 1);
                check("a_hold_data", a_out_data, prev_data_a);
            end
            if (a_out_valid && a_out_ready) begin
                if (qa.size() == 0) begin
                    check("a_spurious_out", a_out_valid, 0);
                end else begin
                    ea = qa.pop_front();
                    check("a_data", a_out_data, ea.data);
                    if (lat_chk) check("a_latency", cyc - ea.cyc, LAT);
                end
            end
            if (a_flush) qa.delete();
            if (a_in_valid && a_in_ready) begin
                ea.data = exp_a(a_in_sel);
                ea.cyc  = cyc;
                qa.push_back(ea);
            end
            prev_stall_a = a_out_valid && !a_out_ready && !a_flush;
            prev_data_a  = a_out_data;

            if (prev_stall_b) begin
                check("b_hold_valid", b_out_valid, 1);
                check("b_hold_data", b_out_data, prev_data_b);
            end
            if (b_out_valid && b_out_ready) begin
                if (qb.size() == 0) begin
                    check("b_spurious_out", b_out_valid, 0);
                end else begin
                    eb = qb.pop_front();
                    check("b_data", b_out_data, eb.data);
                    if (lat_chk) check("b_latency", cyc - eb.cyc, LAT);
                end
            end
            if (b_in_valid && b_in_ready) begin
                eb.data = exp_b(b_in_sel);
                eb.cyc  = cyc;
                qb.push_back(eb);
            end
            prev_stall_b = b_out_valid && !b_out_ready;
            prev_data_b  = b_out_data;
        end
    end

    task automatic send_a(input logic [3:0] sel);
        int  tries;
        bit  done;
        tries = 0;
        done  = 1'b0;
        a_in_valid = 1'b1;
        a_in_sel   = sel;
        while (!done) begin
            @(negedge clk);
            done = a_in_ready;
            @(posedge clk);
            #1;
            tries++;
            if (!done && tries > 50) begin
                check("a_send_timeout", a_in_ready, 1);
                done = 1'b1;
            end
        end
        a_in_valid = 1'b0;
    endtask

    task automatic send_b(input logic [2:0] sel);
        int  tries;
        bit  done;
        tries = 0;
        done  = 1'b0;
        b_in_valid = 1'b1;
        b_in_sel   = sel;
        while (!done) begin
            @(negedge clk);
            done = b_in_ready;
            @(posedge clk);
            #1;
            tries++;
            if (!done && tries > 50) begin
                check("b_send_timeout", b_in_ready, 1);
                done = 1'b1;
            end
        end
        b_in_valid = 1'b0;
    endtask

    task automatic drain_a();
        int n;
        n = 0;
        while ((qa.size() != 0 || a_out_valid) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("a_drain_empty", qa.size(), 0);
    endtask

    task automatic drain_b();
        int n;
        n = 0;
        while ((qb.size() != 0 || b_out_valid) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("b_drain_empty", qb.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got %0d checks, expected completion", n_checks);
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < N_A; i++) a_in_data[i*W_A +: W_A] = 8'(8'h11 * i);
        for (int i = 0; i < N_B; i++) b_in_data[i*W_B +: W_B] = 16'(16'h0101 * i);
        a_flush = 1'b0; a_in_valid = 1'b0; a_in_sel = '0; a_out_ready = 1'b1;
        b_flush = 1'b0; b_in_valid = 1'b0; b_in_sel = '0; b_out_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_a_out_valid", a_out_valid, 0);
        check("rst_a_out_data", a_out_data, 0);
        check("rst_a_in_ready", a_in_ready, 1);
        check("rst_b_out_valid", b_out_valid, 0);
        check("rst_b_in_ready", b_in_ready, 1);
        @(posedge clk);
        #1;

        // Single beat, sel=5
        lat_chk = 1'b1;
        send_a(4'd5);
        check("s2_valid_early", a_out_valid, 0);
        @(posedge clk);
        #1;
        check("s2_valid", a_out_valid, 1);
        check("s2_data", a_out_data, 8'h55);
        @(posedge clk);
        #1;
        check("s2_valid_after", a_out_valid, 0);

        // Back-to-back full sweep
        for (int i = 0; i < N_A; i++) begin
            a_in_valid = 1'b1;
            a_in_sel   = 4'(i);
            @(negedge clk);
            check("s3_in_ready", a_in_ready, 1);
            @(posedge clk);
            #1;
        end
        a_in_valid = 1'b0;
        drain_a();

        // Same stream with a 5-cycle output stall
        lat_chk = 1'b0;
        fork
            begin
                for (int i = 0; i < N_A; i++) send_a(4'(i));
            end
            begin
                repeat (6) @(posedge clk);
                #1;
                a_out_ready = 1'b0;
                for (int c = 0; c < 5; c++) begin
                    @(negedge clk);
                    check("s4_in_ready_low", a_in_ready, 0);
                    @(posedge clk);
                    #1;
                end
                a_out_ready = 1'b1;
            end
        join
        drain_a();

        // Flush with two beats in flight
        a_out_ready = 1'b0;
        send_a(4'd1);
        send_a(4'd2);
        a_flush    = 1'b1;
        a_in_valid = 1'b1;
        a_in_sel   = 4'd7;
        @(negedge clk);
        check("s5_in_ready_flush", a_in_ready, 0);
        check("s5_out_valid_pre", a_out_valid, 1);
        @(posedge clk);
        #1;
        a_flush    = 1'b0;
        a_in_valid = 1'b0;
        check("s5_out_valid_post", a_out_valid, 0);
        a_out_ready = 1'b1;
        lat_chk = 1'b1;
        send_a(4'd3);
        @(posedge clk);
        #1;
        check("s5_valid", a_out_valid, 1);
        check("s5_data", a_out_data, 8'h33);
        drain_a();

        // Asynchronous reset mid-stream
        a_out_ready = 1'b0;
        send_a(4'd9);
        send_a(4'd10);
        check("mrst_in_flight", a_out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mrst_out_valid", a_out_valid, 0);
        check("mrst_out_data", a_out_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        a_out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("mrst_no_resurrect", a_out_valid, 0);

        // Odd select width: sweep all words
        for (int i = 0; i < N_B; i++) send_b(3'(i));
        drain_b();

        // Odd select width with random back-pressure
        lat_chk = 1'b0;
        fork
            begin
                for (int i = 0; i < 20; i++) send_b(3'($urandom_range(0, 7)));
            end
            begin
                for (int c = 0; c < 40; c++) begin
                    b_out_ready = ($urandom_range(0, 2) != 0);
                    @(posedge clk);
                    #1;
                end
                b_out_ready = 1'b1;
            end
        join
        b_out_ready = 1'b1;
        drain_b();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
